// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: shift opcodes, FSM states,
// default datapath width and the round-robin grant helper.
package shift_arbiter_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int SHAMT_WIDTH        = 5;

    localparam logic [1:0] SHIFT_L  = 2'b00;
    localparam logic [1:0] SHIFT_Z  = 2'b01;
    localparam logic [1:0] SHIFT_LR = 2'b10;
    localparam logic [1:0] SHIFT_AR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Port 1 wins when it is the only requester, or on contention when
    // port 0 was the one served last. Otherwise port 0 is selected.
    function automatic logic pick_port(input logic v0, input logic v1, input logic last_grant);
        return v1 & (~v0 | ~last_grant);
    endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter shared by both requesters of the arbiter.
module shifter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [1:0]             op,
    output logic [DATA_WIDTH-1:0]  result
);

    // Select the shift flavour; opcode 01 deliberately yields zero.
    always_comb begin
        result = '0;
        case (op)
            SHIFT_L:  result = a << shamt;
            SHIFT_LR: result = a >> shamt;
            SHIFT_AR: result = DATA_WIDTH'($signed(a) >>> shamt);
            SHIFT_Z:  result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for the shared shifter. Each accepted
// request is captured, shifted in one cycle and held on its owner's
// response channel until consumed.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [1:0]            req0_op,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_result,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [1:0]            req1_op,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_result,

    output logic                  busy,
    output logic [31:0]           op_count
);

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   port_q, port_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
    logic [1:0]             op_q, op_d;
    logic                   resp0_valid_q, resp0_valid_d;
    logic                   resp1_valid_q, resp1_valid_d;
    logic [DATA_WIDTH-1:0]  resp0_result_q, resp0_result_d;
    logic [DATA_WIDTH-1:0]  resp1_result_q, resp1_result_d;
    logic                   busy_q, busy_d;
    logic [31:0]            op_count_q, op_count_d;

    logic                   any_valid;
    logic                   grant_port;
    logic [DATA_WIDTH-1:0]  shift_result;
    logic                   unused_b_bits;

    // Only the low five bits of B carry the shift amount.
    assign unused_b_bits = ^{req0_B[DATA_WIDTH-1:SHAMT_WIDTH], req1_B[DATA_WIDTH-1:SHAMT_WIDTH]};

    // Round-robin grant and the combinational ready strobes offered in IDLE.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_port = pick_port(req0_valid, req1_valid, last_grant_q);
        req0_ready = (state_q == IDLE) && req0_valid && !grant_port;
        req1_ready = (state_q == IDLE) && grant_port;
    end

    shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .a      (a_q),
        .shamt  (shamt_q),
        .op     (op_q),
        .result (shift_result)
    );

    // Sequencing: capture on grant, register the shift, hold until consumed.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        port_d         = port_q;
        a_d            = a_q;
        shamt_d        = shamt_q;
        op_d           = op_q;
        resp0_valid_d  = resp0_valid_q;
        resp1_valid_d  = resp1_valid_q;
        resp0_result_d = resp0_result_q;
        resp1_result_d = resp1_result_q;
        op_count_d     = op_count_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    port_d       = grant_port;
                    last_grant_d = grant_port;
                    a_d          = grant_port ? req1_A : req0_A;
                    shamt_d      = grant_port ? req1_B[SHAMT_WIDTH-1:0] : req0_B[SHAMT_WIDTH-1:0];
                    op_d         = grant_port ? req1_op : req0_op;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp0_valid_d  = !port_q;
                resp1_valid_d  = port_q;
                resp0_result_d = port_q ? '0 : shift_result;
                resp1_result_d = port_q ? shift_result : '0;
                state_d        = RESP;
            end
            RESP: begin
                if (port_q ? resp1_ready : resp0_ready) begin
                    resp0_valid_d  = 1'b0;
                    resp1_valid_d  = 1'b0;
                    resp0_result_d = '0;
                    resp1_result_d = '0;
                    op_count_d     = op_count_q + 32'd1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            port_q         <= 1'b0;
            a_q            <= '0;
            shamt_q        <= '0;
            op_q           <= '0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp1_result_q <= '0;
            busy_q         <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            port_q         <= port_d;
            a_q            <= a_d;
            shamt_q        <= shamt_d;
            op_q           <= op_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp0_result_q <= resp0_result_d;
            resp1_result_q <= resp1_result_d;
            busy_q         <= busy_d;
            op_count_q     <= op_count_d;
        end
    end

    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp0_result = resp0_result_q;
    assign resp1_result = resp1_result_q;
    assign busy         = busy_q;
    assign op_count     = op_count_q;

endmodule
